// File: rtl/alu_share_ctrl_if.sv
// Client-side request/response bundle for the shared ALU controller.
// master = the two clients, slave = the controller.
interface alu_share_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SELW  = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [SELW-1:0]  req_sel0;
    logic [SELW-1:0]  req_sel1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zf;
    logic             rsp_err;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zf, rsp_err
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zf, rsp_err
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one combinational ALU between two clients,
// with illegal-op / divide-by-zero screening on the captured result.
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SELW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic             winner;
    logic             last_grant;
    logic             gnt;
    logic             accept;
    logic             consume;
    logic             bad_op;
    logic [WIDTH-1:0] op_a, op_b;
    logic [SELW-1:0]  op_sel;
    logic [WIDTH-1:0] res_q;
    logic             zf_q, err_q;

    // Tie goes to whichever client was not served last.
    always_comb begin
        gnt = 1'b0;
        case (bus.req_valid)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

    always_comb begin
        bad_op = (op_sel == SELW'(4'b0011)) || (op_sel == SELW'(4'b1010)) ||
                 (op_sel == SELW'(4'b1111)) ||
                 ((op_sel == SELW'(4'b1000)) && (op_b == '0));
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        consume       = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    accept        = 1'b1;
                    bus.req_ready = 2'b01 << gnt;
                    state_nx      = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                bus.rsp_valid = 2'b01 << winner;
                if (bus.rsp_ready[winner]) begin
                    consume  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner     <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            res_q      <= '0;
            zf_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                winner <= gnt;
                op_a   <= gnt ? bus.req_a1   : bus.req_a0;
                op_b   <= gnt ? bus.req_b1   : bus.req_b0;
                op_sel <= gnt ? bus.req_sel1 : bus.req_sel0;
            end
            if (state == EXEC) begin
                res_q <= bad_op ? '0   : alu_res;
                zf_q  <= bad_op ? 1'b1 : alu_zf;
                err_q <= bad_op;
            end
            if (consume) last_grant <= winner;
        end
    end

    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign alu_sel     = op_sel;
    assign bus.rsp_res = res_q;
    assign bus.rsp_zf  = zf_q;
    assign bus.rsp_err = err_q;
    assign busy        = (state != IDLE);
endmodule
